// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RISC-V load/store front end for the word-addressed memory block.
// Define LSU_ROM_WRITE_PROTECT_EN to reject stores that decode to the ROM region.
`ifndef MEM_ROM
`define MEM_ROM 1'b0
`endif
`ifndef MEM_RAM
`define MEM_RAM 1'b1
`endif

module load_store_unit #(
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter int          WORD_BITS = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_type,
  input  logic [31:0] mem_output_data
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        w_accept, w_ram, w_legal, w_misal, w_prot, w_err;
  logic [31:0] w_off, w_idx;
  logic [1:0]  w_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_mask, w_ins, w_merge;
  logic [31:0] w_rdata_n, w_addr_n, w_wdata_n;
  logic        w_err_n, w_type_n;
  assign w_accept = req_valid && r_state == IDLE;
  assign w_ram    = req_addr >= RAM_BASE;
  assign w_off    = w_ram ? req_addr - RAM_BASE : req_addr;
  // Index bits above WORD_BITS are dropped so the index wraps within the array
  assign w_idx    = (w_off >> 2) & ((32'd1 << WORD_BITS) - 32'd1);
  assign w_lane   = w_off[1:0];
  assign w_legal  = req_write ? req_funct3 inside {3'b000, 3'b001, 3'b010}
                              : req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_misal  = (req_funct3[1:0] == 2'b01 && w_lane[0]) || (req_funct3[1:0] == 2'b10 && w_lane != 2'b00);
`ifdef LSU_ROM_WRITE_PROTECT_EN
  assign w_prot   = req_write && !w_ram;
`else
  assign w_prot   = 1'b0;
`endif
  assign w_err    = !w_legal || w_misal || w_prot;
  assign w_byte   = 8'(mem_output_data >> {r_lane, 3'b000});
  assign w_half   = r_lane[1] ? mem_output_data[31:16] : mem_output_data[15:0];
  assign w_ext    = r_f3[1:0] == 2'b00 ? {{24{!r_f3[2] & w_byte[7]}}, w_byte}
                  : r_f3[1:0] == 2'b01 ? {{16{!r_f3[2] & w_half[15]}}, w_half}
                  : mem_output_data;
  // Halfword stores are lane-aligned, so 8*lane equals 16*lane[1]
  assign w_mask   = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {r_lane, 3'b000};
  assign w_ins    = (r_f3[0] ? {16'h0, r_wdata[15:0]} : {24'h0, r_wdata[7:0]}) << {r_lane, 3'b000};
  assign w_merge  = (mem_output_data & ~w_mask) | w_ins;
  always_comb begin
    w_next = r_state == IDLE ? (!req_valid ? IDLE : w_err ? RESP
                                : (req_write && req_funct3[1:0] == 2'b10) ? WR : RD)
           : r_state == RD   ? (r_write ? WR : RESP)
           : r_state == WR   ? RESP
           : IDLE;
  end
  always_comb begin
    w_rdata_n = (r_state == RD && !r_write) ? w_ext : 32'h0;
    w_err_n   = w_accept && w_err;
    w_addr_n  = w_accept ? w_idx : mem_address;
    w_type_n  = w_accept ? (w_ram ? `MEM_RAM : `MEM_ROM) : mem_type;
    w_wdata_n = w_next == WR ? (r_state == RD ? w_merge : req_wdata) : mem_input_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= 32'h0;
      mem_input_data <= 32'h0;
      mem_type       <= `MEM_ROM;
    end else begin
      r_state        <= w_next;
      req_ready      <= w_next == IDLE;
      resp_valid     <= w_next == RESP;
      resp_err       <= w_err_n;
      resp_rdata     <= w_rdata_n;
      mem_read       <= w_next == RD;
      mem_write      <= w_next == WR;
      mem_address    <= w_addr_n;
      mem_input_data <= w_wdata_n;
      mem_type       <= w_type_n;
    end
  end
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write <= req_write;
      r_f3    <= req_funct3;
      r_lane  <= w_lane;
      r_wdata <= req_wdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized check of load_store_unit against a byte-array memory model.
`ifndef MEM_ROM
`define MEM_ROM 1'b0
`endif
`ifndef MEM_RAM
`define MEM_RAM 1'b1
`endif

module tb_load_store_unit;
  localparam logic [31:0] RB = 32'h8000_0000;
  logic        clock = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write, mem_type;
  logic [31:0] resp_rdata, mem_address, mem_input_data, mem_output_data;
  logic [31:0] mem [2][32];
  logic [31:0] init_mem [2][32];
  logic        load_mem = 1'b0;
  logic [7:0]  ref_b [2][128];
  int          total = 0, passes = 0;
  int          exp_lat, exp_rd, exp_wr, exp_idx, exp_t;
  logic [31:0] exp_rdata, got_rdata, wr_data_seen;
  logic        exp_err, exp_w, exp_type, got_err, wr_type_seen;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_input_data(mem_input_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_type(mem_type), .mem_output_data(mem_output_data)
  );

  function automatic int tsel(logic t);
    return (t == `MEM_RAM) ? 1 : 0;
  endfunction

  always @(negedge clock) if (mem_read) mem_output_data <= mem[tsel(mem_type)][mem_address[4:0]];
  always @(posedge clock) begin
    if (load_mem) mem <= init_mem;
    else if (mem_write) mem[tsel(mem_type)][mem_address[4:0]] <= mem_input_data;
  end

  function automatic logic [31:0] ref_word(int t, int i);
    return {ref_b[t][4*i+3], ref_b[t][4*i+2], ref_b[t][4*i+1], ref_b[t][4*i]};
  endfunction

  task automatic set_word(int t, int i, logic [31:0] v);
    init_mem[t][i] = v;
    for (int k = 0; k < 4; k++) ref_b[t][4*i+k] = v[8*k +: 8];
  endtask

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
  endtask

  // Reference: byte-granular memory and the access rules, no notion of FSM states
  task automatic model(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    logic ram, bad;
    logic [31:0] off, v;
    int lane, sz, base;
    ram  = a >= RB;
    off  = ram ? a - RB : a;
    lane = int'(off % 4);
    exp_idx = int'((off / 4) % 32);
    exp_t = ram ? 1 : 0;
    exp_type = ram ? `MEM_RAM : `MEM_ROM;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bad = bad || (lane % sz) != 0;
`ifdef LSU_ROM_WRITE_PROTECT_EN
    bad = bad || (w && !ram);
`endif
    base = exp_idx * 4 + lane;
    exp_w = w; exp_err = bad; exp_rdata = 0; exp_rd = 0; exp_wr = 0;
    if (bad) exp_lat = 1;
    else if (!w) begin
      v = 0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_b[exp_t][base+k];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      exp_rdata = v; exp_lat = 2; exp_rd = 1;
    end else begin
      for (int k = 0; k < sz; k++) ref_b[exp_t][base+k] = wd[8*k +: 8];
      exp_wr = 1; exp_rd = (sz < 4) ? 1 : 0; exp_lat = (sz < 4) ? 3 : 2;
    end
  endtask

  task automatic run_txn(logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    bit seen;
    int nrd, nwr;
    @(negedge clock);
    chk("idle_ready", req_ready, 1);
    chk("idle_no_resp", resp_valid, 0);
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    model(w, f3, a, wd);
    @(posedge clock);
    #1;
    req_valid = 0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    seen = 0; nrd = 0; nwr = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clock);
      chk("strobe_excl", mem_read & mem_write, 0);
      chk("busy_not_ready", req_ready, 0);
      if (mem_read || mem_write) begin
        chk("mem_address", mem_address, exp_idx);
        chk("mem_type", mem_type, exp_type);
      end
      if (mem_write) begin wr_data_seen = mem_input_data; wr_type_seen = mem_type; end
      nrd += int'(mem_read); nwr += int'(mem_write);
      if (resp_valid) begin
        seen = 1;
        got_rdata = resp_rdata; got_err = resp_err;
        chk("latency", c, exp_lat);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, exp_err);
        chk("read_count", nrd, exp_rd);
        chk("write_count", nwr, exp_wr);
        if (exp_w && !exp_err) chk("mem_word", mem[exp_t][exp_idx], ref_word(exp_t, exp_idx));
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL resp_timeout: no resp_valid within 6 cycles, expected after %0d", exp_lat);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0] f3;
    int sz;
    for (int t = 0; t < 2; t++) for (int i = 0; i < 32; i++) set_word(t, i, $urandom);
    set_word(1, 3, 32'hDEADBEEF);
    load_mem = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_input_data", mem_input_data, 0);
    chk("rst_mem_type", mem_type, `MEM_ROM);
    @(posedge clock);
    #1 reset = 0; load_mem = 0;

    run_txn(0, 3'b010, RB + 12, 0); chk("lit_lw", got_rdata, 32'hDEADBEEF);
    run_txn(0, 3'b000, RB + 13, 0); chk("lit_lb", got_rdata, 32'hFFFFFFBE);
    run_txn(0, 3'b100, RB + 13, 0); chk("lit_lbu", got_rdata, 32'h000000BE);
    run_txn(0, 3'b001, RB + 14, 0); chk("lit_lh", got_rdata, 32'hFFFFDEAD);
    run_txn(1, 3'b000, RB + 13, 32'h00000011); chk("lit_sb_merge", wr_data_seen, 32'hDEAD11EF);
    run_txn(0, 3'b010, RB + 12, 0); chk("lit_lw_after_sb", got_rdata, 32'hDEAD11EF);
    run_txn(0, 3'b001, RB + 1, 0); chk("lit_lh_misaligned", got_err, 1);
    run_txn(0, 3'b010, RB + 2, 0); chk("lit_lw_misaligned", got_err, 1);
    run_txn(0, 3'b011, RB, 0);     chk("lit_f3_illegal", got_err, 1);
    run_txn(1, 3'b010, 32'h0, 32'h12345678);
`ifdef LSU_ROM_WRITE_PROTECT_EN
    chk("lit_rom_protect_err", got_err, 1);
`else
    chk("lit_rom_write_type", wr_type_seen, `MEM_ROM);
`endif

    // Reset while an SB sits in RD: aborted, nothing written, no response
    @(negedge clock);
    req_valid = 1; req_write = 1; req_funct3 = 3'b000; req_addr = RB + 20; req_wdata = $urandom;
    @(posedge clock);
    #1 req_valid = 0;
    @(negedge clock);
    chk("rst_rd_strobe", mem_read, 1);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_rd_ready", req_ready, 1);
    chk("rst_rd_mem_read", mem_read, 0);
    chk("rst_rd_mem_write", mem_write, 0);
    chk("rst_rd_resp", resp_valid, 0);
    repeat (3) begin @(negedge clock); chk("rst_rd_no_resp", resp_valid, 0); end
    chk("rst_rd_mem_kept", mem[1][5], ref_word(1, 5));

    // Reset on the edge ending WR of an SW: write still lands
    @(negedge clock);
    a = $urandom;
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = RB + 24; req_wdata = a;
    model(1, 3'b010, RB + 24, a);
    @(posedge clock);
    #1 req_valid = 0;
    @(negedge clock);
    chk("rst_wr_strobe", mem_write, 1);
    reset = 1;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_wr_ready", req_ready, 1);
    chk("rst_wr_mem_write", mem_write, 0);
    chk("rst_wr_resp", resp_valid, 0);
    chk("rst_wr_committed", mem[1][6], ref_word(1, 6));

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = RB + $urandom_range(0, 255);
        1: a = $urandom_range(0, 255);
        2: a = RB - 8 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      f3 = 3'($urandom_range(0, 7));
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      run_txn(1'($urandom), f3, a, $urandom);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
